// File: rtl/lights_mode_ctrl.sv
// rtl/lights_mode_ctrl.sv - button debounce, press detect and auto-advance for the LED pattern selects
// Optional 2-flop input synchronizer enabled by defining LIGHTS_BTN_SYNC_EN.
module lights_mode_ctrl #(
   parameter int DEB_CYCLES  = 16,
   parameter int AUTO_PERIOD = 50000000,
   parameter int MODE_NUM    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn,
   input  logic       auto_en,
   output logic [1:0] sel_0,
   output logic [1:0] sel_1,
   output logic [1:0] sel_2,
   output logic       sel_chg,
   output logic [2:0] btn_db
);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam int AW = $clog2(AUTO_PERIOD);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
   localparam logic [1:0]    SEL_MAX   = 2'(MODE_NUM - 1);

   logic [2:0]    w_b;
   logic [2:0]    w_press;
   logic [2:0]    w_adv;
   logic          w_tick;
   logic [2:0]    r_btn_db;
   logic [DW-1:0] r_deb_cnt [3];
   logic [AW-1:0] r_auto_cnt;
   logic [1:0]    r_sel [3];
   logic          r_sel_chg;

`ifdef LIGHTS_BTN_SYNC_EN
   logic [2:0] r_sync_0;
   logic [2:0] r_sync_1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_0 <= '0;
         r_sync_1 <= '0;
      end else begin
         r_sync_0 <= btn;
         r_sync_1 <= r_sync_0;
      end
   end

   assign w_b = r_sync_1;
`else
   assign w_b = btn;
`endif

   // Any sample equal to the debounced level restarts the qualification run.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            r_deb_cnt[i] <= '0;
            r_btn_db[i]  <= 1'b0;
         end else if (w_b[i] == r_btn_db[i]) begin
            r_deb_cnt[i] <= '0;
         end else if (r_deb_cnt[i] == DEB_LAST) begin
            r_deb_cnt[i] <= '0;
            r_btn_db[i]  <= w_b[i];
         end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !auto_en) begin
         r_auto_cnt <= '0;
      end else if (r_auto_cnt == AUTO_LAST) begin
         r_auto_cnt <= '0;
      end else begin
         r_auto_cnt <= r_auto_cnt + 1'b1;
      end
   end

   assign w_tick = auto_en & (r_auto_cnt == AUTO_LAST);

   always_comb begin
      w_press = '0;
      w_adv   = '0;
      for (int i = 0; i < 3; i++) begin
         w_press[i] = w_b[i] & ~r_btn_db[i] & (r_deb_cnt[i] == DEB_LAST);
         w_adv[i]   = w_press[i] | w_tick;
      end
   end

   // A press coinciding with a tick still advances the channel only once.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            r_sel[i] <= 2'(i % MODE_NUM);
         end else if (w_adv[i]) begin
            r_sel[i] <= (r_sel[i] == SEL_MAX) ? 2'd0 : r_sel[i] + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel_chg <= 1'b0;
      end else begin
         r_sel_chg <= |w_adv;
      end
   end

   assign sel_0   = r_sel[0];
   assign sel_1   = r_sel[1];
   assign sel_2   = r_sel[2];
   assign sel_chg = r_sel_chg;
   assign btn_db  = r_btn_db;
endmodule

// File: tb/tb_lights_mode_ctrl.sv
// tb/tb_lights_mode_ctrl.sv - self-checking bench for lights_mode_ctrl
module tb_lights_mode_ctrl;
   localparam int DEB = 4;
   localparam int AP  = 8;
   localparam int MN  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       auto_en = 1'b0;
   logic [2:0] btn = 3'b000;
   logic [1:0] sel_0, sel_1, sel_2;
   logic       sel_chg;
   logic [2:0] btn_db;

   lights_mode_ctrl #(
      .DEB_CYCLES(DEB),
      .AUTO_PERIOD(AP),
      .MODE_NUM(MN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn(btn),
      .auto_en(auto_en),
      .sel_0(sel_0),
      .sel_1(sel_1),
      .sel_2(sel_2),
      .sel_chg(sel_chg),
      .btn_db(btn_db)
   );

   always #5 clk = ~clk;

   // Model: a channel's stable level flips once its last DEB samples all disagree with it;
   // each sel is its reset offset plus the number of advance events, modulo MN.
   logic [DEB-1:0] m_hist [3] = '{default: '0};
   logic [2:0]     m_db  = 3'b000;
   int             m_adv [3] = '{0, 0, 0};
   int             m_run = 0;
   logic           m_chg = 1'b0;

   function automatic int m_sel(input int i);
      return (i + m_adv[i]) % MN;
   endfunction

   always @(posedge clk) begin
      logic tick;
      logic press;
      logic any;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_hist[i] = '0;
            m_adv[i]  = 0;
         end
         m_db  = 3'b000;
         m_run = 0;
         m_chg = 1'b0;
      end else begin
         tick = 1'b0;
         any  = 1'b0;
         if (auto_en) begin
            m_run = m_run + 1;
            tick  = (m_run % AP) == 0;
         end else begin
            m_run = 0;
         end
         for (int i = 0; i < 3; i++) begin
            press     = 1'b0;
            m_hist[i] = {m_hist[i][DEB-2:0], btn[i]};
            if (m_hist[i] == {DEB{~m_db[i]}}) begin
               press   = ~m_db[i];
               m_db[i] = ~m_db[i];
            end
            if (press || tick) begin
               m_adv[i] = m_adv[i] + 1;
               any      = 1'b1;
            end
         end
         m_chg = any;
      end
   end

   typedef struct {
      string name;
      int    sig;
      int    exp;
   } lit_t;

   lit_t lit_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   chg_seen = 0;
   bit   started = 1'b0;

   function automatic int dut_val(input int sig);
      case (sig)
         0:       return int'(sel_0);
         1:       return int'(sel_1);
         2:       return int'(sel_2);
         3:       return int'(sel_chg);
         4:       return int'(btn_db);
         default: return chg_seen;
      endcase
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      lit_t l;
      #1;
      if (started) begin
         if (sel_chg) chg_seen = chg_seen + 1;
         cmp("model sel_0", int'(sel_0), m_sel(0));
         cmp("model sel_1", int'(sel_1), m_sel(1));
         cmp("model sel_2", int'(sel_2), m_sel(2));
         cmp("model sel_chg", int'(sel_chg), int'(m_chg));
         cmp("model btn_db", int'(btn_db), int'(m_db));
         while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            cmp(l.name, dut_val(l.sig), l.exp);
         end
      end
   end

   task automatic want(input string nm, input int sig, input int exp);
      lit_t l;
      l.name = nm;
      l.sig  = sig;
      l.exp  = exp;
      lit_q.push_back(l);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic want_sels(input string nm, input int a, input int b, input int c);
      want({nm, " sel_0"}, 0, a);
      want({nm, " sel_1"}, 1, b);
      want({nm, " sel_2"}, 2, c);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      bit pat [8];
      int wrap_exp [3];
      pat      = '{1, 1, 1, 0, 1, 1, 1, 0};
      wrap_exp = '{3, 0, 1};

      // reset and idle
      cyc(2);
      started = 1'b1;
      want_sels("reset", 0, 1, 2);
      want("reset sel_chg", 3, 0);
      want("reset btn_db", 4, 0);
      rst = 1'b0;
      cyc(20);
      want_sels("idle", 0, 1, 2);
      want("idle pulses", 5, 0);

      // clean press on channel 0
      btn = 3'b001;
      cyc(3);
      want("press edge3 sel_0", 0, 0);
      want("press edge3 btn_db", 4, 0);
      cyc(1);
      want("press edge4 sel_0", 0, 1);
      want("press edge4 sel_chg", 3, 1);
      want("press edge4 btn_db", 4, 1);
      cyc(6);
      want("held sel_0", 0, 1);
      want("held sel_chg", 3, 0);
      btn = 3'b000;
      cyc(3);
      want("release edge3 btn_db", 4, 1);
      cyc(1);
      want("release edge4 btn_db", 4, 0);
      want("release sel_0", 0, 1);
      want("press pulses", 5, 1);

      // bounce on channel 1
      for (int k = 0; k < 8; k++) begin
         btn[1] = pat[k];
         cyc(1);
      end
      want("bounce btn_db", 4, 0);
      want("bounce sel_1", 1, 1);
      btn[1] = 1'b1;
      cyc(4);
      want("bounce settle sel_1", 1, 2);
      want("bounce settle btn_db", 4, 2);
      btn = 3'b000;
      cyc(6);
      want("bounce pulses", 5, 2);

      // wrap on channel 2
      do_reset();
      want("wrap start sel_2", 2, 2);
      for (int k = 0; k < 3; k++) begin
         btn[2] = 1'b1;
         cyc(5);
         btn[2] = 1'b0;
         cyc(6);
         want("wrap sel_2", 2, wrap_exp[k]);
      end
      want("wrap pulses", 5, 5);

      // auto advance
      do_reset();
      auto_en = 1'b1;
      cyc(7);
      want_sels("auto edge7", 0, 1, 2);
      cyc(1);
      want_sels("auto tick1", 1, 2, 3);
      want("auto tick1 sel_chg", 3, 1);
      cyc(7);
      want("auto edge15 sel_0", 0, 1);
      cyc(1);
      want_sels("auto tick2", 2, 3, 0);
      cyc(1);
      want("auto edge17 sel_chg", 3, 0);
      auto_en = 1'b0;
      cyc(1);
      auto_en = 1'b1;
      cyc(5);
      auto_en = 1'b0;
      cyc(1);
      auto_en = 1'b1;
      cyc(7);
      want("auto restart edge7 sel_0", 0, 2);
      cyc(1);
      want_sels("auto restart tick", 3, 0, 1);
      auto_en = 1'b0;
      cyc(2);
      want("auto pulses", 5, 8);

      // press coinciding with tick
      do_reset();
      auto_en = 1'b1;
      cyc(4);
      btn = 3'b001;
      cyc(4);
      want_sels("collide", 1, 2, 3);
      want("collide sel_chg", 3, 1);
      auto_en = 1'b0;
      btn = 3'b000;
      cyc(6);
      want("collide pulses", 5, 9);

      // reset on the would-be press edge
      btn = 3'b001;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      want_sels("rst press", 0, 1, 2);
      want("rst press sel_chg", 3, 0);
      want("rst press btn_db", 4, 0);
      rst = 1'b0;
      btn = 3'b000;
      cyc(3);
      want("rst press pulses", 5, 9);

      @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
